ase_hssi_tx_pkt_buffer: RTL

- Store-and-forward Ethernet packet buffer on the AFU-to-host HSSI path. It sits directly upstream of the per-channel HSSI emulator TX stream.
- It accepts AXI-S beats from AFU logic and releases a packet to the emulator only once its tlast beat is stored. The emulator therefore never sees a partial packet stall mid-frame.
- It honours the link-level tx_pause at packet boundaries and drops packets that cannot fit in the buffer.

---
 rtl/ase_hssi_pkg.sv | 22 ++
 rtl/ase_hssi_sdp_ram.sv | 23 ++
 rtl/ase_hssi_tx_pkt_buffer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ase_hssi_pkg.sv
// Shared types for the HSSI TX packet buffer: default stream widths, beat layout and FSM encodings.
package ase_hssi_pkg;

  localparam int HSSI_TDATA_WIDTH = 64;
  localparam int HSSI_TKEEP_WIDTH = HSSI_TDATA_WIDTH / 8;
  localparam int HSSI_TUSER_WIDTH = 1;

  typedef struct packed {
    logic                        tlast;
    logic [HSSI_TUSER_WIDTH-1:0] tuser;
    logic [HSSI_TKEEP_WIDTH-1:0] tkeep;
    logic [HSSI_TDATA_WIDTH-1:0] tdata;
  } t_hssi_tx_beat;

  typedef enum logic {ACCEPT, DROP} t_wr_state;
  typedef enum logic {IDLE, SEND} t_rd_state;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ase_hssi_sdp_ram.sv
// Simple dual-port RAM with a registered read port; the array itself is never reset.
module ase_hssi_sdp_ram #(
  parameter int WIDTH      = 74,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ase_hssi_tx_pkt_buffer.sv
// Store-and-forward AXI-S packet buffer in front of the HSSI emulator TX stream.
// Packets are released only once fully stored; oversize packets are dropped.
module ase_hssi_tx_pkt_buffer
  import ase_hssi_pkg::*;
#(
  parameter int TDATA_WIDTH = HSSI_TDATA_WIDTH,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH = HSSI_TUSER_WIDTH,
  parameter int DEPTH       = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  input  logic [TDATA_WIDTH-1:0]     in_tdata,
  input  logic [TKEEP_WIDTH-1:0]     in_tkeep,
  input  logic [TUSER_WIDTH-1:0]     in_tuser,
  input  logic                       in_tlast,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [TDATA_WIDTH-1:0]     out_tdata,
  output logic [TKEEP_WIDTH-1:0]     out_tkeep,
  output logic [TUSER_WIDTH-1:0]     out_tuser,
  output logic                       out_tlast,
  input  logic                       tx_pause,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic [$clog2(DEPTH):0]     used_beats,
  output logic [31:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 1 + TUSER_WIDTH + TKEEP_WIDTH + TDATA_WIDTH;

  // Handshakes: a beat moves when valid && ready are both high at a rising clk edge.
  t_wr_state        wr_state;
  t_rd_state        rd_state;
  logic [PW-1:0]    wr_ptr, wr_commit_ptr, rd_ptr, rd_addr;
  logic             ready_en, full, in_fire, out_fire, rd_en, deadlock;
  logic             commit, sent, q_vld;
  logic [1:0]       occ;
  logic [BW-1:0]    ram_q, head, skid;

  assign used_beats = wr_ptr - rd_ptr;
  assign full       = (used_beats == PW'(DEPTH));
  assign in_tready  = ready_en && ((wr_state == DROP) || !full);
  assign in_fire    = in_tvalid && in_tready;
  assign commit     = in_fire && (wr_state == ACCEPT) && in_tlast;
  // A partial packet filling the whole buffer can never commit, so it is abandoned.
  assign deadlock   = (wr_state == ACCEPT) && full && (pkt_count == '0) && (wr_ptr != wr_commit_ptr);

  assign out_tvalid = (rd_state == SEND) && (occ != 2'd0);
  assign out_fire   = out_tvalid && out_tready;
  assign sent       = out_fire && out_tlast;
  assign {out_tlast, out_tuser, out_tkeep, out_tdata} = head;

  // Prefetch runs ahead over committed beats only, limited by the two-entry skid stage.
  assign rd_en = (rd_addr != wr_commit_ptr) &&
                 (({1'b0, occ} + {2'b00, q_vld} - {2'b00, out_fire}) < 3'd2);

  ase_hssi_sdp_ram #(.WIDTH(BW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) u_ram (
    .clk   (clk),
    .we    (in_fire && (wr_state == ACCEPT)),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({in_tlast, in_tuser, in_tkeep, in_tdata}),
    .re    (rd_en),
    .raddr (rd_addr[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state      <= ACCEPT;
      wr_ptr        <= '0;
      wr_commit_ptr <= '0;
      drop_count    <= '0;
      ready_en      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (wr_state)
        ACCEPT: begin
          if (deadlock) begin
            wr_ptr     <= wr_commit_ptr;
            drop_count <= sat_inc32(drop_count);
            wr_state   <= DROP;
          end else if (in_fire) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (in_tlast) wr_commit_ptr <= wr_ptr + PW'(1);
          end
        end
        DROP: if (in_fire && in_tlast) wr_state <= ACCEPT;
        default: wr_state <= ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= IDLE;
      rd_addr   <= '0;
      rd_ptr    <= '0;
      q_vld     <= 1'b0;
      occ       <= 2'd0;
      head      <= '0;
      skid      <= '0;
      pkt_count <= '0;
    end else begin
      q_vld <= rd_en;
      if (rd_en)    rd_addr <= rd_addr + PW'(1);
      if (out_fire) rd_ptr  <= rd_ptr + PW'(1);

      case (rd_state)
        IDLE:    if ((pkt_count != '0) && !tx_pause) rd_state <= SEND;
        SEND:    if (sent) rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase

      case ({commit, sent})
        2'b10:   pkt_count <= pkt_count + PW'(1);
        2'b01:   pkt_count <= pkt_count - PW'(1);
        default: pkt_count <= pkt_count;
      endcase

      // head is the presented beat, skid catches the RAM word that lands during a stall.
      case ({q_vld, out_fire})
        2'b11: begin
          if (occ == 2'd1) head <= ram_q;
          else begin
            head <= skid;
            skid <= ram_q;
          end
        end
        2'b10: begin
          if (occ == 2'd0) head <= ram_q;
          else             skid <= ram_q;
        end
        2'b01:   if (occ == 2'd2) head <= skid;
        default: ;
      endcase
      occ <= occ + {1'b0, q_vld} - {1'b0, out_fire};
    end
  end

endmodule
